// File: rtl/bus_client_burst.sv
// bus_client_burst: traffic-generating master for the arbitrated rq/ack bus.
// Issues single bursts of BURST_LEN beats (write, read, write-then-verify or
// LFSR-random direction), captures read data and counts readback mismatches.
//
// Handshake: rq is held high from the cycle after a burst starts. While rq=1,
// address/wr_ni/dataW stay stable until ack=1 is sampled on a rising edge; that
// edge completes the current beat and rq stays high for the next one. ack seen
// while rq=0 has no effect. If TIMEOUT_CYCLES consecutive rq cycles pass without
// ack, the burst is abandoned and replayed later from the same base address.
module bus_client_burst #(
  parameter int         DATA_WIDTH           = 8,
  parameter int         ADDR_WIDTH           = 4,
  parameter int         ADDR_SPACE_BEGINNING = 0,
  parameter int         ADDR_SPACE_END       = 3,
  parameter int         BURST_LEN            = 4,
  parameter int         TIMEOUT_CYCLES       = 16,
  parameter logic [7:0] LFSR_SEED            = 8'h2D,
  parameter int         ERR_WIDTH            = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [1:0]            mode,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  rq,
  input  logic                  ack,
  output logic                  wr_ni,
  output logic [DATA_WIDTH-1:0] dataW,
  input  logic [DATA_WIDTH-1:0] dataR,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic                  timeout,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int TMO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [ADDR_WIDTH-1:0] ADDR_BEG  = ADDR_WIDTH'(ADDR_SPACE_BEGINNING);
  localparam logic [ADDR_WIDTH-1:0] ADDR_END  = ADDR_WIDTH'(ADDR_SPACE_END);
  localparam logic [BEAT_W-1:0]     BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] DATA_STEP = DATA_WIDTH'(BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_XFER   = 2'd1,
    S_VERIFY = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [7:0]            lfsr_q;
  logic                  lfsr_fb;
  logic [1:0]            mode_q;        // mode latched at burst start
  logic [ADDR_WIDTH-1:0] addr_q;        // current beat address / next burst base when idle
  logic [ADDR_WIDTH-1:0] base_addr_q;   // base of the burst in flight
  logic [DATA_WIDTH-1:0] data_base_q;   // data base for the next burst
  logic [DATA_WIDTH-1:0] burst_data_q;  // data base of the burst in flight
  logic [BEAT_W-1:0]     beat_q;
  logic [TMO_W-1:0]      tmo_q;
  logic                  wr_ni_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic [ERR_WIDTH-1:0]  err_q;
  logic                  timeout_q;

  logic                  start_burst;
  logic                  beat_done;
  logic                  phase_last;
  logic                  enter_verify;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [DATA_WIDTH-1:0] beat_data;

  // x^8 + x^6 + x^5 + x^4 + 1, free-running left shift
  assign lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign addr_next = (addr_q == ADDR_END) ? ADDR_BEG : addr_q + ADDR_WIDTH'(1);
  assign beat_data = burst_data_q + DATA_WIDTH'(beat_q);

  assign address   = addr_q;
  assign rq        = (state_q != S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign wr_ni     = wr_ni_q;
  assign dataW     = beat_data;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign err_count = err_q;
  assign timeout   = timeout_q;
  assign state_dbg = state_q;

  // LFSR advances every clock; it gates burst starts and picks mode-3 direction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_fb};
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and beat-level decisions
  always_comb begin
    state_d      = state_q;
    start_burst  = 1'b0;
    beat_done    = 1'b0;
    phase_last   = 1'b0;
    enter_verify = 1'b0;
    abort        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && lfsr_q[0]) begin
          start_burst = 1'b1;
          state_d     = S_XFER;
        end
      end
      S_XFER, S_VERIFY: begin
        if (ack) begin
          beat_done = 1'b1;
          if (beat_q == BEAT_LAST) begin
            phase_last = 1'b1;
            if ((state_q == S_XFER) && (mode_q == 2'd2)) begin
              enter_verify = 1'b1;
              state_d      = S_VERIFY;
            end else begin
              state_d = S_IDLE;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Burst bookkeeping: address, beat index, data bases, direction, timeout count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q       <= 2'd0;
      addr_q       <= ADDR_BEG;
      base_addr_q  <= ADDR_BEG;
      data_base_q  <= '0;
      burst_data_q <= '0;
      beat_q       <= '0;
      tmo_q        <= '0;
      wr_ni_q      <= 1'b0;
    end else if (start_burst) begin
      mode_q       <= mode;
      base_addr_q  <= addr_q;
      burst_data_q <= data_base_q;
      beat_q       <= '0;
      tmo_q        <= '0;
      wr_ni_q      <= (mode == 2'd1) || ((mode == 2'd3) && lfsr_q[1]);
    end else if (beat_done) begin
      tmo_q <= '0;
      if (phase_last) begin
        beat_q <= '0;
        // only a completed write phase consumes data values
        if (!wr_ni_q) begin
          data_base_q <= data_base_q + DATA_STEP;
        end
        if (enter_verify) begin
          addr_q  <= base_addr_q;
          wr_ni_q <= 1'b1;
        end else begin
          addr_q  <= addr_next;
          wr_ni_q <= 1'b0;
        end
      end else begin
        beat_q <= beat_q + BEAT_W'(1);
        addr_q <= addr_next;
      end
    end else if (abort) begin
      // replay later from the same base; data base untouched
      addr_q  <= base_addr_q;
      wr_ni_q <= 1'b0;
      beat_q  <= '0;
      tmo_q   <= '0;
    end else if (state_q != S_IDLE) begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  // Read capture, verify error count and timeout pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      rd_valid_q <= beat_done && wr_ni_q;
      timeout_q  <= abort;
      if (beat_done && wr_ni_q) begin
        rd_data_q <= dataR;
      end
      if (beat_done && (state_q == S_VERIFY) && (dataR != beat_data) && (err_q != '1)) begin
        err_q <= err_q + ERR_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_bus_client_burst.sv
// Testbench for bus_client_burst: directed burst table, hand-written corner
// sequences (timeout, reset mid-verify, error saturation) and a randomized run
// against a transaction-level reference model.
module tb_bus_client_burst;

  localparam int BL  = 4;
  localparam int BEG = 0;
  localparam int WIN = 4;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic [1:0] mode;
  logic [3:0] address;
  logic       rq;
  logic       ack;
  logic       wr_ni;
  logic [7:0] dataW;
  logic [7:0] dataR;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] err_count;
  logic       timeout;
  logic       busy;
  logic [1:0] state_dbg;

  int checks;
  int failures;

  bus_client_burst dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .mode      (mode),
    .address   (address),
    .rq        (rq),
    .ack       (ack),
    .wr_ni     (wr_ni),
    .dataW     (dataW),
    .dataR     (dataR),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .err_count (err_count),
    .timeout   (timeout),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- bus memory and scoreboard ----------------
  logic [7:0] mem [16];
  logic [7:0] exp_q[$];

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0] addr;
    logic       rd;
    logic [7:0] data;
    logic       verify;
  } beat_t;

  beat_t      pend_q[$];
  logic [7:0] m_lfsr;
  int         m_next;
  int         m_dbase;
  int         m_err;
  logic       exp_rdv;
  logic [7:0] exp_rd;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  // Expand one burst into its expected beats, in bus order
  task automatic push_burst(input logic [1:0] md, input logic l1);
    beat_t b;
    logic  rd;
    rd = (md == 2'd1) || ((md == 2'd3) && l1);
    for (int k = 0; k < BL; k++) begin
      b.addr   = 4'(BEG + ((m_next + k) % WIN));
      b.rd     = rd;
      b.data   = 8'(m_dbase + k);
      b.verify = 1'b0;
      pend_q.push_back(b);
    end
    if (md == 2'd2) begin
      for (int k = 0; k < BL; k++) begin
        b.addr   = 4'(BEG + ((m_next + k) % WIN));
        b.rd     = 1'b1;
        b.data   = 8'(m_dbase + k);
        b.verify = 1'b1;
        pend_q.push_back(b);
      end
    end
    m_next = (m_next + BL) % WIN;
    if (!rd) m_dbase = (m_dbase + BL) % 256;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0] mode;
    int         corrupt;  // verify beat whose readback is corrupted, -1 none
    logic       exp_rd;   // direction of first phase
    logic [7:0] d0;       // first write value
    logic [7:0] r0;       // first value read back in a plain read burst
    int         exp_err;  // err_count after the burst
  } vec_t;

  vec_t vecs[6];

  int         nb;
  int         k;
  int         ph;
  int         cnt;
  int         n_reads;
  int         nack;
  int         fail_base;
  logic       exp_dir;
  logic       rq_exp;
  logic       ak;
  logic       corrupt;
  logic       chk200;
  logic [7:0] dr;
  logic [7:0] rv;
  beat_t      b;

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    enable   = 1'b0;
    mode     = 2'd0;
    ack      = 1'b1;
    dataR    = 8'h00;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    vecs[0] = '{2'd0, -1, 1'b0, 8'd0,  8'd0,  0};
    vecs[1] = '{2'd0, -1, 1'b0, 8'd4,  8'd0,  0};
    vecs[2] = '{2'd2, -1, 1'b0, 8'd8,  8'd0,  0};
    vecs[3] = '{2'd2,  2, 1'b0, 8'd12, 8'd0,  1};
    vecs[4] = '{2'd1, -1, 1'b1, 8'd0,  8'd12, 1};
    vecs[5] = '{2'd0, -1, 1'b0, 8'd16, 8'd0,  1};

    // ---- reset values with ack forced high ----
    repeat (3) @(negedge clk);
    chk("rst_rq", rq, 0);
    chk("rst_wr_ni", wr_ni, 0);
    chk("rst_address", address, BEG);
    chk("rst_dataW", dataW, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("idle_no_enable_rq", rq, 0);
    end

    // ---- directed bursts ----
    for (int v = 0; v < 6; v++) begin
      mode   = vecs[v].mode;
      ack    = 1'b1;
      enable = 1'b1;
      exp_q.delete();
      for (int c = 0; c < 64 && !rq; c++) @(negedge clk);
      chk("vec_start", rq, 1);
      enable = 1'b0;
      nb = 0;
      for (int c = 0; c < 40; c++) begin
        if (c > 0) @(negedge clk);
        if (rd_valid) begin
          if (exp_q.size() == 0) chk("vec_rd_unexpected", rd_valid, 0);
          else chk("vec_rd_data", rd_data, exp_q.pop_front());
        end
        if (!rq) break;
        k  = nb % BL;
        ph = nb / BL;
        exp_dir = (ph == 1) ? 1'b1 : vecs[v].exp_rd;
        chk("vec_address", address, k);
        chk("vec_wr_ni", wr_ni, exp_dir);
        if (!exp_dir) begin
          rv = vecs[v].d0 + 8'(k);
          chk("vec_dataW", dataW, rv);
          mem[k] = rv;
        end else begin
          rv = (ph == 1) ? vecs[v].d0 + 8'(k) : vecs[v].r0 + 8'(k);
          dr = mem[k];
          if (ph == 1 && k == vecs[v].corrupt) begin
            dr = dr ^ 8'hFF;
            rv = rv ^ 8'hFF;
          end
          dataR = dr;
          exp_q.push_back(rv);
        end
        nb++;
      end
      chk("vec_beats", nb, (vecs[v].mode == 2'd2) ? 2 * BL : BL);
      chk("vec_rd_left", exp_q.size(), 0);
      chk("vec_err", err_count, vecs[v].exp_err);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk("vec_stays_idle", rq, 0);
      end
    end

    // ---- timeout during beat 1, then replay ----
    apply_reset();
    mode   = 2'd0;
    ack    = 1'b1;
    enable = 1'b1;
    for (int c = 0; c < 64 && !rq; c++) @(negedge clk);
    chk("tmo_start", rq, 1);
    enable = 1'b0;
    @(negedge clk);
    chk("tmo_beat1_addr", address, 1);
    ack = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (timeout) break;
      if (rq) cnt++;
      @(negedge clk);
    end
    chk("tmo_pulse", timeout, 1);
    chk("tmo_cycles", cnt, 16);
    chk("tmo_rq", rq, 0);
    chk("tmo_busy", busy, 0);
    chk("tmo_addr_restored", address, 0);
    @(negedge clk);
    chk("tmo_pulse_end", timeout, 0);
    ack    = 1'b1;
    enable = 1'b1;
    for (int c = 0; c < 64 && !rq; c++) @(negedge clk);
    chk("replay_start", rq, 1);
    enable = 1'b0;
    chk("replay_addr", address, 0);
    chk("replay_dataW", dataW, 0);
    chk("replay_wr_ni", wr_ni, 0);
    for (int c = 0; c < 20 && rq; c++) @(negedge clk);
    chk("replay_done", rq, 0);

    // ---- reset pulsed mid-verify ----
    apply_reset();
    mode   = 2'd2;
    ack    = 1'b1;
    dataR  = 8'hAA;
    enable = 1'b1;
    for (int c = 0; c < 64 && !rq; c++) @(negedge clk);
    enable = 1'b0;
    for (int c = 0; c < 20 && !(rq && wr_ni); c++) @(negedge clk);
    chk("rmv_in_verify", wr_ni, 1);
    @(negedge clk);
    chk("rmv_err_pre", err_count, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rmv_rq", rq, 0);
    chk("rmv_busy", busy, 0);
    chk("rmv_wr_ni", wr_ni, 0);
    chk("rmv_address", address, 0);
    chk("rmv_dataW", dataW, 0);
    chk("rmv_rd_valid", rd_valid, 0);
    chk("rmv_rd_data", rd_data, 0);
    chk("rmv_err", err_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("rmv_no_resume", rq, 0);
    end

    // ---- error counter saturation ----
    apply_reset();
    mode    = 2'd2;
    ack     = 1'b1;
    enable  = 1'b1;
    n_reads = 0;
    chk200  = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (n_reads == 200 && !chk200) begin
        chk("sat_err_200", err_count, 200);
        chk200 = 1'b1;
      end
      if (rq && wr_ni) begin
        dataR = ~mem[address];
        n_reads++;
      end else if (rq) begin
        mem[address] = dataW;
      end
      if (n_reads >= 300) enable = 1'b0;
      if (n_reads >= 300 && !rq) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk("sat_reads", (n_reads >= 300), 1);
    chk("sat_err_255", err_count, 255);

    // ---- randomized run against the reference model ----
    apply_reset();
    pend_q.delete();
    m_lfsr    = 8'h2D;
    m_next    = 0;
    m_dbase   = 0;
    m_err     = 0;
    exp_rdv   = 1'b0;
    exp_rd    = 8'h00;
    nack      = 0;
    fail_base = failures;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      rq_exp = (pend_q.size() > 0);
      chk("rnd_rq", rq, rq_exp);
      chk("rnd_busy", busy, rq_exp);
      chk("rnd_timeout", timeout, 0);
      chk("rnd_rd_valid", rd_valid, exp_rdv);
      if (exp_rdv) chk("rnd_rd_data", rd_data, exp_rd);
      chk("rnd_err", err_count, m_err);
      if (rq_exp) begin
        chk("rnd_address", address, pend_q[0].addr);
        chk("rnd_wr_ni", wr_ni, pend_q[0].rd);
        if (!pend_q[0].rd) chk("rnd_dataW", dataW, pend_q[0].data);
      end
      enable  = ($urandom_range(0, 9) != 0);
      mode    = 2'($urandom_range(0, 3));
      ak      = ($urandom_range(0, 1) == 1) || (rq_exp && nack >= 5);
      nack    = (rq_exp && !ak) ? nack + 1 : 0;
      corrupt = ($urandom_range(0, 5) == 0);
      dr      = 8'($urandom);
      if (rq_exp && pend_q[0].rd) dr = mem[pend_q[0].addr] ^ (corrupt ? 8'h5A : 8'h00);
      if (rq_exp && !pend_q[0].rd && ak) mem[pend_q[0].addr] = pend_q[0].data;
      ack   = ak;
      dataR = dr;
      exp_rdv = 1'b0;
      if (rq_exp) begin
        if (ak) begin
          b = pend_q.pop_front();
          if (b.rd) begin
            exp_rdv = 1'b1;
            exp_rd  = dr;
          end
          if (b.verify && dr != b.data && m_err != 255) m_err++;
        end
      end else if (enable && m_lfsr[0]) begin
        push_burst(mode, m_lfsr[1]);
      end
      m_lfsr = lfsr_step(m_lfsr);
      if (failures > fail_base + 40) break;
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
